// File: rtl/matrix_loader.sv
// Frame parser that unpacks a serial matrix/vector frame (FE, N, N*N matrix, N vector, EF)
// into row-FIFO and vector-FIFO write strobes, then launches the processor FSM.
module matrix_loader #(
  parameter int MAX_N  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              proc_done,
  output logic [3:0]        N,
  output logic [DATA_W-1:0] push_data,
  output logic [MAX_N-1:0]  mat_push,
  output logic              vec_push,
  output logic              flush,
  output logic              start,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GET_N   = 3'd1;
  localparam logic [2:0] S_MATRIX  = 3'd2;
  localparam logic [2:0] S_VECTOR  = 3'd3;
  localparam logic [2:0] S_TRAILER = 3'd4;
  localparam logic [2:0] S_START   = 3'd5;
  localparam logic [2:0] S_WAIT    = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;

  localparam logic [DATA_W-1:0] HEADER  = DATA_W'(8'hFE);
  localparam logic [DATA_W-1:0] TRAILER = DATA_W'(8'hEF);
  localparam logic [DATA_W-1:0] MAX_N_B = DATA_W'(MAX_N);
  localparam logic [MAX_N-1:0]  ROW0    = MAX_N'(1);

  logic [2:0]        state_q,     state_d;
  logic [3:0]        n_q,         n_d;
  logic [3:0]        row_q,       row_d;
  logic [3:0]        col_q,       col_d;
  logic [3:0]        vcnt_q,      vcnt_d;
  logic [DATA_W-1:0] push_data_q, push_data_d;
  logic [MAX_N-1:0]  mat_push_q,  mat_push_d;
  logic              vec_push_q,  vec_push_d;
  logic              flush_q,     flush_d;
  logic              start_q,     start_d;
  logic              err_q,       err_d;
  logic [3:0]        n_last;

  assign n_last = n_q - 4'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    n_d         = n_q;
    row_d       = row_q;
    col_d       = col_q;
    vcnt_d      = vcnt_q;
    push_data_d = push_data_q;
    mat_push_d  = '0;
    vec_push_d  = 1'b0;
    flush_d     = 1'b0;
    start_d     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == HEADER) begin
          state_d = S_GET_N;
          flush_d = 1'b1;
        end
      end

      S_GET_N: begin
        if (rx_valid) begin
          if (rx_data != '0 && rx_data <= MAX_N_B) begin
            n_d     = rx_data[3:0];
            row_d   = 4'd0;
            col_d   = 4'd0;
            vcnt_d  = 4'd0;
            state_d = S_MATRIX;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            flush_d = 1'b1;
          end
        end
      end

      S_MATRIX: begin
        if (rx_valid) begin
          push_data_d = rx_data;
          mat_push_d  = ROW0 << row_q;
          if (col_q == n_last) begin
            col_d = 4'd0;
            if (row_q == n_last) begin
              row_d   = 4'd0;
              state_d = S_VECTOR;
            end else begin
              row_d = row_q + 4'd1;
            end
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end

      S_VECTOR: begin
        if (rx_valid) begin
          push_data_d = rx_data;
          vec_push_d  = 1'b1;
          if (vcnt_q == n_last) begin
            vcnt_d  = 4'd0;
            state_d = S_TRAILER;
          end else begin
            vcnt_d = vcnt_q + 4'd1;
          end
        end
      end

      S_TRAILER: begin
        if (rx_valid) begin
          if (rx_data == TRAILER) begin
            state_d = S_START;
            start_d = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            flush_d = 1'b1;
          end
        end
      end

      S_START: state_d = S_WAIT;

      S_WAIT: begin
        if (proc_done) state_d = S_IDLE;
      end

      S_ERROR: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Pulse outputs are registered on the transition, so they are high during the START/ERROR cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      n_q         <= 4'd0;
      row_q       <= 4'd0;
      col_q       <= 4'd0;
      vcnt_q      <= 4'd0;
      push_data_q <= '0;
      mat_push_q  <= '0;
      vec_push_q  <= 1'b0;
      flush_q     <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q     <= state_d;
      n_q         <= n_d;
      row_q       <= row_d;
      col_q       <= col_d;
      vcnt_q      <= vcnt_d;
      push_data_q <= push_data_d;
      mat_push_q  <= mat_push_d;
      vec_push_q  <= vec_push_d;
      flush_q     <= flush_d;
      start_q     <= start_d;
      err_q       <= err_d;
    end
  end

  assign N         = n_q;
  assign push_data = push_data_q;
  assign mat_push  = mat_push_q;
  assign vec_push  = vec_push_q;
  assign flush     = flush_q;
  assign start     = start_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: a push scoreboard fed by the frame driver,
// a table of GET_N order bytes, and hand-written corner-case sequences.
module tb_matrix_loader;

  localparam int MAX_N  = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              proc_done = 1'b0;
  logic [3:0]        N;
  logic [DATA_W-1:0] push_data;
  logic [MAX_N-1:0]  mat_push;
  logic              vec_push;
  logic              flush;
  logic              start;
  logic              busy;
  logic              err;

  matrix_loader #(.MAX_N(MAX_N), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .proc_done (proc_done),
    .N         (N),
    .push_data (push_data),
    .mat_push  (mat_push),
    .vec_push  (vec_push),
    .flush     (flush),
    .start     (start),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_vec;
    logic [7:0] mask;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] n_byte;
    bit         ok;
  } nvec_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   start_cnt = 0, err_cnt = 0, flush_cnt = 0, push_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every push strobe.
  always @(negedge clk) begin
    if (rst) begin
      if (start) start_cnt++;
      if (flush) flush_cnt++;
      if (err) begin
        err_cnt++;
        check("err_with_flush", 32'(flush), 32'(1));
      end
      if (mat_push != '0 || vec_push) begin
        push_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_push", {15'd0, vec_push, mat_push, push_data}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("push_vec",  32'(vec_push),  32'(e.is_vec));
          check("push_mask", 32'(mat_push),  32'(e.mask));
          check("push_data", 32'(push_data), 32'(e.data));
        end
      end
    end
  end

  // Called at a falling edge; returns at a falling edge after the byte and its gap.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic expect_mat(input int row, input logic [7:0] d);
    exp_t e;
    logic [7:0] one;
    one = 8'd1;
    e.is_vec = 1'b0;
    e.mask   = one << row;
    e.data   = d;
    sb.push_back(e);
  endtask

  task automatic expect_vec(input logic [7:0] d);
    exp_t e;
    e.is_vec = 1'b1;
    e.mask   = 8'd0;
    e.data   = d;
    sb.push_back(e);
  endtask

  task automatic send_frame(input int n, input logic [7:0] trl, input int gap_max);
    logic [7:0] d;
    send_byte(8'hFE, $urandom_range(gap_max, 0));
    send_byte(8'(n), $urandom_range(gap_max, 0));
    for (int i = 0; i < n * n; i++) begin
      d = 8'($urandom);
      expect_mat(i / n, d);
      send_byte(d, $urandom_range(gap_max, 0));
    end
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      expect_vec(d);
      send_byte(d, $urandom_range(gap_max, 0));
    end
    send_byte(trl, 0);
  endtask

  task automatic pulse_done();
    proc_done = 1'b1;
    @(negedge clk);
    proc_done = 1'b0;
  endtask

  nvec_t ntab[9];
  int s0, e0, f0, p0;

  initial begin
    ntab[0] = '{8'h00, 1'b0};
    ntab[1] = '{8'h01, 1'b1};
    ntab[2] = '{8'h02, 1'b1};
    ntab[3] = '{8'h05, 1'b1};
    ntab[4] = '{8'h08, 1'b1};
    ntab[5] = '{8'h09, 1'b0};
    ntab[6] = '{8'h0F, 1'b0};
    ntab[7] = '{8'h10, 1'b0};
    ntab[8] = '{8'hFF, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_N",         32'(N),         32'd0);
    check("rst_mat_push",  32'(mat_push),  32'd0);
    check("rst_vec_push",  32'(vec_push),  32'd0);
    check("rst_push_data", 32'(push_data), 32'd0);
    check("rst_flush",     32'(flush),     32'd0);
    check("rst_start",     32'(start),     32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic N=2 frame; proc_done mid-frame must be ignored.
    s0 = start_cnt; e0 = err_cnt; f0 = flush_cnt;
    send_byte(8'hFE, 0);
    check("hdr_flush", 32'(flush), 32'd1);
    check("hdr_busy",  32'(busy),  32'd1);
    send_byte(8'h02, 1);
    pulse_done();
    expect_mat(0, 8'h01); expect_mat(0, 8'h02);
    expect_mat(1, 8'h03); expect_mat(1, 8'h04);
    expect_vec(8'h05); expect_vec(8'h06);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
    send_byte(8'hEF, 0);
    check("n2_start_now", 32'(start), 32'd1);
    repeat (3) @(negedge clk);
    check("n2_starts", 32'(start_cnt - s0), 32'd1);
    check("n2_errs",   32'(err_cnt - e0),   32'd0);
    check("n2_flushes",32'(flush_cnt - f0), 32'd1);
    check("n2_N",      32'(N),              32'd2);
    check("n2_wait_busy", 32'(busy),        32'd1);
    check("n2_sb_empty", 32'(sb.size()),    32'd0);

    // Frame received while in WAIT is ignored.
    s0 = start_cnt; f0 = flush_cnt;
    send_byte(8'hFE, 0); send_byte(8'h01, 0); send_byte(8'h05, 0);
    send_byte(8'h06, 0); send_byte(8'hEF, 2);
    check("wait_starts",  32'(start_cnt - s0), 32'd0);
    check("wait_flushes", 32'(flush_cnt - f0), 32'd0);
    check("wait_busy",    32'(busy),           32'd1);
    pulse_done();
    @(negedge clk);
    check("done_idle", 32'(busy), 32'd0);
    s0 = start_cnt;
    send_frame(1, 8'hEF, 0);
    repeat (2) @(negedge clk);
    check("after_wait_start", 32'(start_cnt - s0), 32'd1);
    check("after_wait_N",     32'(N),              32'd1);
    pulse_done();

    // N=1 frame with bad trailer.
    s0 = start_cnt; e0 = err_cnt; f0 = flush_cnt;
    expect_mat(0, 8'h07); expect_vec(8'h08);
    send_byte(8'hFE, 0); send_byte(8'h01, 0); send_byte(8'h07, 0);
    send_byte(8'h08, 0); send_byte(8'hAA, 0);
    check("badtrl_err_now", 32'(err), 32'd1);
    repeat (2) @(negedge clk);
    check("badtrl_errs",    32'(err_cnt - e0),   32'd1);
    check("badtrl_starts",  32'(start_cnt - s0), 32'd0);
    check("badtrl_flushes", 32'(flush_cnt - f0), 32'd2);
    check("badtrl_idle",    32'(busy),           32'd0);
    check("badtrl_sb",      32'(sb.size()),      32'd0);

    // 0xFE inside the payload is data.
    s0 = start_cnt;
    expect_mat(0, 8'hFE); expect_vec(8'hFE);
    send_byte(8'hFE, 0); send_byte(8'h01, 0); send_byte(8'hFE, 0);
    send_byte(8'hFE, 0); send_byte(8'hEF, 2);
    check("fe_payload_start", 32'(start_cnt - s0), 32'd1);
    check("fe_payload_sb",    32'(sb.size()),      32'd0);
    pulse_done();

    // Table of order bytes: valid orders run a full frame, invalid ones must error.
    for (int k = 0; k < 9; k++) begin
      s0 = start_cnt; e0 = err_cnt; f0 = flush_cnt;
      if (ntab[k].ok) begin
        send_frame(int'(ntab[k].n_byte), 8'hEF, 1);
        repeat (2) @(negedge clk);
        check($sformatf("tab%0d_start", k), 32'(start_cnt - s0), 32'd1);
        check($sformatf("tab%0d_err", k),   32'(err_cnt - e0),   32'd0);
        check($sformatf("tab%0d_N", k),     32'(N),              32'(ntab[k].n_byte));
        pulse_done();
        @(negedge clk);
      end else begin
        send_byte(8'hFE, 0);
        send_byte(ntab[k].n_byte, 0);
        check($sformatf("tab%0d_err_now", k), 32'(err), 32'd1);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 2);
        check($sformatf("tab%0d_err", k),   32'(err_cnt - e0),   32'd1);
        check($sformatf("tab%0d_flush", k), 32'(flush_cnt - f0), 32'd2);
        check($sformatf("tab%0d_start", k), 32'(start_cnt - s0), 32'd0);
      end
      check($sformatf("tab%0d_idle", k), 32'(busy),      32'd0);
      check($sformatf("tab%0d_sb", k),   32'(sb.size()), 32'd0);
    end

    // Reset in the middle of an N=3 frame.
    e0 = err_cnt;
    expect_mat(0, 8'h11); expect_mat(0, 8'h22); expect_mat(0, 8'h33);
    send_byte(8'hFE, 0); send_byte(8'h03, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    #2 rst = 1'b0;
    #1;
    check("midrst_mat_push",  32'(mat_push),  32'd0);
    check("midrst_push_data", 32'(push_data), 32'd0);
    check("midrst_N",         32'(N),         32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_flush",     32'(flush),     32'd0);
    check("midrst_err",       32'(err),       32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    check("midrst_sb",     32'(sb.size()),    32'd0);
    s0 = start_cnt;
    send_frame(3, 8'hEF, 1);
    repeat (2) @(negedge clk);
    check("postrst_start", 32'(start_cnt - s0), 32'd1);
    check("postrst_N",     32'(N),              32'd3);
    pulse_done();
    @(negedge clk);

    // N=8 frame with random 0-5 cycle gaps.
    s0 = start_cnt; p0 = push_cnt; e0 = err_cnt;
    send_frame(8, 8'hEF, 5);
    repeat (3) @(negedge clk);
    check("n8_pushes", 32'(push_cnt - p0),  32'd72);
    check("n8_start",  32'(start_cnt - s0), 32'd1);
    check("n8_err",    32'(err_cnt - e0),   32'd0);
    check("n8_N",      32'(N),              32'd8);
    check("n8_sb",     32'(sb.size()),      32'd0);
    pulse_done();
    @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
